// File: rtl/dat_fifo_pkg.sv
// -----------------------------------------------------------------------------
// dat_fifo_pkg
// Shared defaults and derived widths for the DMA -> DAT byte FIFO.
//   DEF_DATA_W : default byte-lane width
//   DEF_DEPTH  : default number of storage entries (power of two)
//   ADDR_W     : pointer width for the default depth
//   BLK_W      : width of the block-size register and block counter
// -----------------------------------------------------------------------------
package dat_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned ADDR_W     = $clog2(DEF_DEPTH);
    localparam int unsigned BLK_W      = 12;

endpackage

// File: rtl/dat_fifo_mem.sv
// -----------------------------------------------------------------------------
// dat_fifo_mem
// Storage array for dat_fifo: one write port and one registered read port.
// The array and the read register have no reset; the parent masks the read
// data until the first valid pop.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe; loads o_rd_data on the rising edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data, held when i_rd_en is low
// -----------------------------------------------------------------------------
module dat_fifo_mem
    import dat_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AW     = ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dat_fifo.sv
// -----------------------------------------------------------------------------
// dat_fifo
// Byte FIFO between the DMA engine and the DAT stage, with block tracking.
// Optional feature macro: DAT_FIFO_ERR_FLAGS_EN enables sticky overflow /
// underflow flags; without it both flags are tied to 0.
// Ports:
//   clk_in_COM     : clock, rising edge
//   reset_in_COM   : asynchronous active-high reset
//   write_in_FIFO  : push request;  data_in_DMA : push data
//   read_in_DAT    : pop request;   data_out_DAT : popped byte (registered)
//   flush_in_DMA   : synchronous clear of contents and block counter
//   block_size_REG : bytes per block, 0 disables block tracking
//   full_FIFO / empty_FIFO / count_FIFO : registered occupancy status
//   block_done_DAT : one-cycle pulse when the last byte of a block is popped
//   overflow_err / underflow_err : sticky error flags
// -----------------------------------------------------------------------------
module dat_fifo
    import dat_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                    clk_in_COM,
    input  logic                    reset_in_COM,
    input  logic                    write_in_FIFO,
    input  logic [DATA_W-1:0]       data_in_DMA,
    input  logic                    read_in_DAT,
    input  logic                    flush_in_DMA,
    input  logic [BLK_W-1:0]        block_size_REG,
    output logic [DATA_W-1:0]       data_out_DAT,
    output logic                    full_FIFO,
    output logic                    empty_FIFO,
    output logic [$clog2(DEPTH):0]  count_FIFO,
    output logic                    block_done_DAT,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
    logic [CNT_W-1:0]  r_count, w_count_d;
    logic              r_full, r_empty, w_full_d, w_empty_d;
    logic              r_dout_vld;
    logic [BLK_W-1:0]  r_blk_cnt, w_blk_cnt_d, r_blk_size, w_blk_size_d;
    logic [BLK_W-1:0]  w_blk_size_eff, w_blk_inc;
    logic              r_blk_done, w_blk_done_d;
    logic              w_push, w_pop;
    logic [DATA_W-1:0] w_rd_data;

    // Accept decisions use the registered flags from before the edge.
    assign w_push = write_in_FIFO & ~r_full;
    assign w_pop  = read_in_DAT & ~r_empty;

    // Pointers, occupancy and status flags
    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;
        if (flush_in_DMA) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            // Power-of-two depth: natural overflow wraps DEPTH-1 to 0.
            if (w_push) w_wr_ptr_d = r_wr_ptr + PTR_W'(1);
            if (w_pop)  w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                w_count_d = r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                w_count_d = r_count - CNT_W'(1);
            end
        end
        w_full_d  = (w_count_d == CNT_W'(DEPTH));
        w_empty_d = (w_count_d == '0);
    end

    // Block tracking: the size is captured at the first pop of each block so
    // that register writes during a block only take effect on the next one.
    always_comb begin
        w_blk_size_eff = (r_blk_cnt == '0) ? block_size_REG : r_blk_size;
        w_blk_inc      = r_blk_cnt + BLK_W'(1);
        w_blk_cnt_d    = r_blk_cnt;
        w_blk_size_d   = r_blk_size;
        w_blk_done_d   = 1'b0;
        if (flush_in_DMA) begin
            w_blk_cnt_d = '0;
        end else if (w_pop) begin
            if (r_blk_cnt == '0) w_blk_size_d = block_size_REG;
            if (w_blk_size_eff != '0) begin
                if (w_blk_inc == w_blk_size_eff) begin
                    w_blk_cnt_d  = '0;
                    w_blk_done_d = 1'b1;
                end else begin
                    w_blk_cnt_d  = w_blk_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_in_COM or posedge reset_in_COM) begin
        if (reset_in_COM) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_dout_vld <= 1'b0;
            r_blk_cnt  <= '0;
            r_blk_size <= '0;
            r_blk_done <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_count    <= w_count_d;
            r_full     <= w_full_d;
            r_empty    <= w_empty_d;
            r_blk_cnt  <= w_blk_cnt_d;
            r_blk_size <= w_blk_size_d;
            r_blk_done <= w_blk_done_d;
            if (w_pop && !flush_in_DMA) r_dout_vld <= 1'b1;
        end
    end

    dat_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_mem (
        .i_clk     (clk_in_COM),
        .i_wr_en   (w_push & ~flush_in_DMA),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in_DMA),
        .i_rd_en   (w_pop & ~flush_in_DMA),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // The read register has no reset; present 0 until the first real pop.
    assign data_out_DAT   = r_dout_vld ? w_rd_data : '0;
    assign full_FIFO      = r_full;
    assign empty_FIFO     = r_empty;
    assign count_FIFO     = r_count;
    assign block_done_DAT = r_blk_done;

`ifdef DAT_FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;

    // Flush takes priority over push/pop, so requests during flush never flag.
    always_ff @(posedge clk_in_COM or posedge reset_in_COM) begin
        if (reset_in_COM) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!flush_in_DMA) begin
            if (write_in_FIFO && r_full)  r_overflow  <= 1'b1;
            if (read_in_DAT && r_empty)   r_underflow <= 1'b1;
        end
    end

    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_dat_fifo.sv
// -----------------------------------------------------------------------------
// tb_dat_fifo
// Directed self-checking bench for dat_fifo (DATA_W=8, DEPTH=16).
// -----------------------------------------------------------------------------
module tb_dat_fifo;

`ifdef DAT_FIFO_ERR_FLAGS_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [7:0]  din;
    logic        rd;
    logic        flush;
    logic [11:0] bsize;
    logic [7:0]  dout;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        done;
    logic        ovf;
    logic        unf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dat_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk_in_COM     (clk),
        .reset_in_COM   (rst),
        .write_in_FIFO  (wr),
        .data_in_DMA    (din),
        .read_in_DAT    (rd),
        .flush_in_DMA   (flush),
        .block_size_REG (bsize),
        .data_out_DAT   (dout),
        .full_FIFO      (full),
        .empty_FIFO     (empty),
        .count_FIFO     (count),
        .block_done_DAT (done),
        .overflow_err   (ovf),
        .underflow_err  (unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"}, 32'(count), 32'd0);
        chk({tag, " empty"}, 32'(empty), 32'd1);
        chk({tag, " full"},  32'(full),  32'd0);
        chk({tag, " dout"},  32'(dout),  32'd0);
        chk({tag, " done"},  32'(done),  32'd0);
        chk({tag, " ovf"},   32'(ovf),   32'd0);
        chk({tag, " unf"},   32'(unf),   32'd0);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; din = '0; rd = 1'b0; flush = 1'b0; bsize = '0;
        #1;
        chk_reset_vals("reset");
        tick();
        rst = 1'b0;

        // Fill: 0x00..0x0F
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; din = 8'(i); tick();
        end
        chk("half count", 32'(count), 32'd8);
        chk("half full", 32'(full), 32'd0);
        for (int i = 8; i < 16; i++) begin
            wr = 1'b1; din = 8'(i); tick();
        end
        chk("fill full", 32'(full), 32'd1);
        chk("fill count", 32'(count), 32'd16);
        chk("fill empty", 32'(empty), 32'd0);

        // 17th push is rejected
        din = 8'h55; tick();
        chk("ovf push count", 32'(count), 32'd16);
        chk("ovf flag", 32'(ovf), 32'(ERR_ON));
        wr = 1'b0; tick();
        chk("ovf sticky", 32'(ovf), 32'(ERR_ON));

        // Push+pop while full: only the pop is accepted
        wr = 1'b1; din = 8'hAA; rd = 1'b1; tick();
        chk("full rw dout", 32'(dout), 32'h00);
        chk("full rw count", 32'(count), 32'd15);
        chk("full rw full", 32'(full), 32'd0);
        // Retry of 0xAA fills the freed slot (write pointer has wrapped to 0)
        rd = 1'b0; tick();
        chk("refill count", 32'(count), 32'd16);
        chk("refill full", 32'(full), 32'd1);
        wr = 1'b0; rd = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("drain pop%0d", k), 32'(dout), (k < 15) ? 32'(k + 1) : 32'hAA);
        end
        rd = 1'b0; tick();
        chk("drain empty", 32'(empty), 32'd1);
        chk("drain count", 32'(count), 32'd0);
        chk("drain unf", 32'(unf), 32'd0);
        chk("ovf still set", 32'(ovf), 32'(ERR_ON));

        // Block tracking: size 4, mid-block writes of block_size ignored
        bsize = 12'd4;
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; din = 8'(8'h10 + i); tick();
        end
        wr = 1'b0; rd = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("blk done pop%0d", k), 32'(done), 32'((k == 4) || (k == 8)));
            chk($sformatf("blk dout pop%0d", k), 32'(dout), 32'(8'h10 + k - 1));
            if (k == 1) bsize = 12'd9;
            if (k == 4) bsize = 12'd4;
        end
        rd = 1'b0; tick();
        chk("blk done idle", 32'(done), 32'd0);
        chk("blk empty", 32'(empty), 32'd1);

        // Partial block, then flush with simultaneous push
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; din = 8'(8'h20 + i); tick();
        end
        wr = 1'b0; rd = 1'b1; tick(); tick();
        chk("pre-flush dout", 32'(dout), 32'h21);
        rd = 1'b0; flush = 1'b1; wr = 1'b1; din = 8'h77; tick();
        chk("flush count", 32'(count), 32'd0);
        chk("flush empty", 32'(empty), 32'd1);
        chk("flush done", 32'(done), 32'd0);
        chk("flush dout hold", 32'(dout), 32'h21);
        flush = 1'b0; wr = 1'b0; rd = 1'b1; tick();
        chk("unf flag", 32'(unf), 32'(ERR_ON));
        chk("unf dout hold", 32'(dout), 32'h21);
        chk("unf count", 32'(count), 32'd0);

        // Block counter was cleared by flush: pulse on 4th pop only
        rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; din = 8'(8'h30 + i); tick();
        end
        wr = 1'b0; rd = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("post-flush done pop%0d", k), 32'(done), 32'(k == 4));
        end
        rd = 1'b0;

        // Asynchronous reset with 6 entries stored
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; din = 8'(8'h40 + i); tick();
        end
        wr = 1'b0;
        chk("pre-rst count", 32'(count), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async rst");
        #1 rst = 1'b0;

        // Pointers restart at 0 after reset
        wr = 1'b1; din = 8'h99; tick();
        wr = 1'b0; rd = 1'b1; tick();
        rd = 1'b0;
        chk("post-rst dout", 32'(dout), 32'h99);
        chk("post-rst count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
